// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared types and helpers for the slice mux/demux pair
package slice_pkg;

    localparam int BYTES_PER_WORD = 32;
    localparam int ACC_BYTES      = 64;
    localparam int WORD_W         = BYTES_PER_WORD * 8;
    localparam int ACC_W          = ACC_BYTES * 8;
    localparam int FILL_W         = $clog2(ACC_BYTES + 1);
    localparam int NBYTES_W       = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHUNK = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Number of 32-byte words a chunk occupies, rounded up.
    function automatic logic [11:0] chunk_words(input logic [15:0] chunk_size);
        logic [16:0] sum;
        sum = {1'b0, chunk_size} + 17'd31;
        return sum[16:5];
    endfunction

endpackage

// File: rtl/slice_byte_packer.sv
// rtl/slice_byte_packer.sv - 64-byte accumulator that packs partial words into a 256-bit stream
module slice_byte_packer
    import slice_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [NBYTES_W-1:0] wr_nbytes,
    input  logic                flush,
    output logic [FILL_W-1:0]   room,
    output logic                empty,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    input  logic                out_ready
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              sof_q, sof_d;

    logic [FILL_W-1:0] pop;
    logic [WORD_W-1:0] wr_masked;
    logic              fire;

    // Bytes at or above fill are always kept zero, so the low half of acc
    // is directly the emitted word including the zero padding at frame end.
    always_comb begin
        out_valid = (fill_q >= FILL_W'(BYTES_PER_WORD)) | (flush & (fill_q != '0));
        fire      = out_valid & out_ready;
        pop       = '0;
        if (fire) begin
            pop = (fill_q >= FILL_W'(BYTES_PER_WORD)) ? FILL_W'(BYTES_PER_WORD) : fill_q;
        end
        room = fill_q - pop;

        wr_masked = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (NBYTES_W'(b) < wr_nbytes) begin
                wr_masked[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end

        acc_d  = fire ? {{WORD_W{1'b0}}, acc_q[ACC_W-1:WORD_W]} : acc_q;
        fill_d = room;
        if (wr_en) begin
            acc_d  = acc_d | ({{WORD_W{1'b0}}, wr_masked} << {room, 3'b000});
            fill_d = room + FILL_W'(wr_nbytes);
        end

        sof_d = fire ? 1'b0 : sof_q;

        if (clear) begin
            acc_d  = '0;
            fill_d = '0;
            sof_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            sof_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            sof_q  <= sof_d;
        end
    end

    assign out_data = acc_q[WORD_W-1:0];
    assign out_sof  = sof_q & out_valid;
    assign out_eof  = flush & (fill_q != '0) & (fill_q <= FILL_W'(BYTES_PER_WORD));
    assign empty    = (fill_q == '0);

endmodule

// File: rtl/slice_mux.sv
// rtl/slice_mux.sv - encoder-side slice interleaver feeding one packed rate-buffer stream
module slice_mux
    import slice_pkg::*;
#(
    parameter int MAX_NBR_SLICES  = 2,
    parameter int MAX_SLICE_WIDTH = 2560
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [9:0]                       slices_per_line,
    input  logic [15:0]                      chunk_size,
    input  logic                             in_sof,
    input  logic                             in_eof,
    input  logic [WORD_W*MAX_NBR_SLICES-1:0] in_data_p,
    input  logic [MAX_NBR_SLICES-1:0]        in_valid,
    output logic [MAX_NBR_SLICES-1:0]        in_ready,
    output logic [WORD_W-1:0]                out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_sof,
    output logic                             out_eof
);

    localparam int AS_W   = (MAX_NBR_SLICES > 1) ? $clog2(MAX_NBR_SLICES) : 1;
    localparam int WCNT_W = $clog2(MAX_SLICE_WIDTH);

    state_e            state_q, state_d;
    logic [AS_W-1:0]   active_slice_q, active_slice_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic              eof_pending_q, eof_pending_d;

    logic [WCNT_W-1:0]   cw;
    logic                last_word;
    logic [4:0]          rem;
    logic [NBYTES_W-1:0] nbytes;
    logic [9:0]          next_slice;
    logic                slot_ready;
    logic                accept;
    logic [WORD_W-1:0]   wr_data;
    logic [FILL_W-1:0]   room;
    logic                packer_empty;

    always_comb begin
        cw         = WCNT_W'(chunk_words(chunk_size));
        last_word  = (word_cnt_q == cw - 1'b1);
        rem        = chunk_size[4:0];
        nbytes     = (last_word && (rem != 5'd0)) ? NBYTES_W'(rem) : NBYTES_W'(BYTES_PER_WORD);
        next_slice = 10'(active_slice_q) + 10'd1;

        // Ready depends only on state, fill and the downstream pop, never on in_valid.
        slot_ready = (state_q == ST_CHUNK) & (room <= FILL_W'(BYTES_PER_WORD));
        in_ready   = slot_ready ? (MAX_NBR_SLICES'(1) << active_slice_q) : '0;
        accept     = slot_ready & in_valid[active_slice_q];
        wr_data    = in_data_p[active_slice_q*WORD_W +: WORD_W];
    end

    always_comb begin
        state_d        = state_q;
        active_slice_d = active_slice_q;
        word_cnt_d     = word_cnt_q;
        eof_pending_d  = eof_pending_q | in_eof;

        case (state_q)
            ST_IDLE: begin
            end
            ST_CHUNK: begin
                if (accept) begin
                    if (last_word) begin
                        word_cnt_d     = '0;
                        active_slice_d = (next_slice >= slices_per_line) ? '0 : AS_W'(next_slice);
                        if (eof_pending_q | in_eof) begin
                            state_d       = ST_FLUSH;
                            eof_pending_d = 1'b0;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (packer_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new frame overrides whatever was in progress.
        if (in_sof) begin
            state_d        = ST_CHUNK;
            active_slice_d = '0;
            word_cnt_d     = '0;
            eof_pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            active_slice_q <= '0;
            word_cnt_q     <= '0;
            eof_pending_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_slice_q <= active_slice_d;
            word_cnt_q     <= word_cnt_d;
            eof_pending_q  <= eof_pending_d;
        end
    end

    slice_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (in_sof),
        .wr_en     (accept & ~in_sof),
        .wr_data   (wr_data),
        .wr_nbytes (nbytes),
        .flush     (state_q == ST_FLUSH),
        .room      (room),
        .empty     (packer_empty),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_slice_mux.sv
// tb/tb_slice_mux.sv - scoreboard bench for the slice interleaver
module tb_slice_mux;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [9:0]       slices_per_line = 10'd2;
    logic [15:0]      chunk_size = 16'd64;
    logic             in_sof = 1'b0;
    logic             in_eof = 1'b0;
    logic [256*N-1:0] in_data_p = '0;
    logic [N-1:0]     in_valid = '0;
    logic [N-1:0]     in_ready;
    logic [255:0]     out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_sof;
    logic             out_eof;

    slice_mux #(.MAX_NBR_SLICES(N), .MAX_SLICE_WIDTH(2560)) dut (
        .clk             (clk),
        .rst             (rst),
        .slices_per_line (slices_per_line),
        .chunk_size      (chunk_size),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .in_data_p       (in_data_p),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sof         (out_sof),
        .out_eof         (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        bit           sof;
        bit           eof;
    } exp_t;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   tb_bytes[$];
    exp_t         exp_q[$];
    bit           sof_next = 1'b0;
    int           ready_mode = 0;
    int           out_words = 0;
    bit           hold_q = 1'b0;
    logic [255:0] hold_data;
    logic         hold_sof;
    logic         hold_eof;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic make_words();
        exp_t e;
        while (tb_bytes.size() >= 32) begin
            e.data = '0;
            for (int b = 0; b < 32; b++) e.data[b*8 +: 8] = tb_bytes.pop_front();
            e.sof = sof_next;
            e.eof = 1'b0;
            sof_next = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_model();
        exp_t e;
        int   n;
        make_words();
        if (tb_bytes.size() > 0) begin
            e.data = '0;
            n = tb_bytes.size();
            for (int b = 0; b < n; b++) e.data[b*8 +: 8] = tb_bytes.pop_front();
            e.sof = sof_next;
            e.eof = 1'b1;
            sof_next = 1'b0;
            exp_q.push_back(e);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            e.eof = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            check("in_ready_onehot", 256'($countones(in_ready) <= 1), 256'd1);
            if (hold_q) begin
                check("hold_valid", 256'(out_valid), 256'd1);
                check("hold_data", out_data, hold_data);
                check("hold_sof", 256'(out_sof), 256'(hold_sof));
                check("hold_eof", 256'(out_eof), 256'(hold_eof));
            end
            if (out_valid && out_ready) begin
                out_words++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 256'(exp_q.size()), 256'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sof", 256'(out_sof), 256'(e.sof));
                    check("out_eof", 256'(out_eof), 256'(e.eof));
                end
            end
            hold_q    = out_valid & ~out_ready;
            hold_data = out_data;
            hold_sof  = out_sof;
            hold_eof  = out_eof;
        end
    end

    task automatic start_frame();
        in_sof = 1'b1;
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        tb_bytes.delete();
        exp_q.delete();
        sof_next  = 1'b1;
        hold_q    = 1'b0;
        out_words = 0;
    endtask

    task automatic drive(input int s, input int nb, input bit eof);
        logic [255:0] w;
        bit           ok;
        w  = rand_word();
        ok = 1'b0;
        in_data_p[s*256 +: 256] = w;
        in_valid[s] = 1'b1;
        in_eof = eof;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[s]) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 256'(ok), 256'd1);
        end else begin
            for (int b = 0; b < nb; b++) tb_bytes.push_back(w[b*8 +: 8]);
            make_words();
            if (eof) flush_model();
        end
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic drain(input int exp_words);
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drained", 256'(exp_q.size()), 256'd0);
        check("word_count", 256'(out_words), 256'(exp_words));
        check("idle_valid", 256'(out_valid), 256'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_out_sof", 256'(out_sof), 256'd0);
        check("rst_out_eof", 256'(out_eof), 256'd0);
        check("rst_out_data", out_data, 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // word-aligned chunks, eof on the last word
        chunk_size = 16'd64; slices_per_line = 10'd2;
        start_frame();
        drive(0, 32, 0); drive(0, 32, 0); drive(1, 32, 0); drive(1, 32, 1);
        drain(4);

        // 40-byte chunks straddle word boundaries
        chunk_size = 16'd40;
        start_frame();
        drive(0, 32, 0); drive(0, 8, 0); drive(1, 32, 0); drive(1, 8, 1);
        drain(3);

        // same pattern under random backpressure, two lines
        ready_mode = 1;
        start_frame();
        for (int l = 0; l < 2; l++) begin
            drive(0, 32, 0); drive(0, 8, 0); drive(1, 32, 0); drive(1, 8, l == 1);
        end
        drain(5);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // single slice per line, 33-byte chunks
        slices_per_line = 10'd1; chunk_size = 16'd33;
        start_frame();
        for (int c = 0; c < 3; c++) begin
            drive(0, 32, 0); drive(0, 1, c == 2);
        end
        drain(4);

        // asynchronous reset with 20 bytes buffered and slice 1 active
        slices_per_line = 10'd2; chunk_size = 16'd20;
        start_frame();
        drive(0, 20, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 256'(out_valid), 256'd0);
        check("rst_mid_ready", 256'(in_ready), 256'd0);
        check("rst_mid_data", out_data, 256'd0);
        tb_bytes.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_frame();
        drive(0, 20, 0); drive(1, 20, 1);
        drain(2);

        // in_sof while a stalled word is buffered mid-chunk
        chunk_size = 16'd80; ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        start_frame();
        drive(0, 32, 0);
        @(negedge clk);
        check("stall_valid", 256'(out_valid), 256'd1);
        @(posedge clk);
        #1;
        start_frame();
        @(negedge clk);
        check("sof_discard_valid", 256'(out_valid), 256'd0);
        check("sof_discard_eof", 256'(out_eof), 256'd0);
        ready_mode = 0;
        @(posedge clk);
        #1;
        drive(0, 32, 0); drive(0, 32, 0); drive(0, 16, 0);
        drive(1, 32, 0); drive(1, 32, 0); drive(1, 16, 1);
        drain(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
